// File: rtl/alu4_ctrl.sv
// alu4_ctrl: command-side controller for the 4-bit ALU.
// Takes commands over a valid/ready handshake, drives the combinational ALU
// from operand registers, captures the result one cycle later and returns it
// over a second valid/ready handshake. Keeps a chaining accumulator and a
// count of results the consumer has taken.
module alu4_ctrl #(
  parameter int          CNT_W    = 8,
  parameter logic [3:0]  ACC_INIT = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_wr_acc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_s,
  input  logic             alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_s,
  output logic             res_c,
  output logic [3:0]       acc,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] opnd_a;
  logic [3:0] opnd_b;
  logic [1:0] opnd_op;
  logic       opnd_wr;
  logic       take_cmd;
  logic [3:0] next_a;

  // The ALU is driven directly from the operand registers, so its inputs
  // only move when a new command is latched.
  assign alu_a  = opnd_a;
  assign alu_b  = opnd_b;
  assign alu_op = opnd_op;

  // A command can be taken when idle, or in HOLD in the same cycle the
  // pending result is handed over; never a function of cmd_valid.
  assign cmd_ready = (state == IDLE) | ((state == HOLD) & res_ready);
  assign take_cmd  = cmd_valid & cmd_ready;

  // Operand A source; in HOLD the accumulator already carries the value
  // written by the preceding EXEC, which gives chaining for free.
  assign next_a = cmd_use_acc ? acc : cmd_a;

  // Controller state, operand registers, result capture, accumulator and
  // completed-operation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd_a    <= 4'h0;
      opnd_b    <= 4'h0;
      opnd_op   <= 2'd0;
      opnd_wr   <= 1'b0;
      res_valid <= 1'b0;
      res_s     <= 4'h0;
      res_c     <= 1'b0;
      acc       <= ACC_INIT;
      op_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_cmd) begin
            opnd_a  <= next_a;
            opnd_b  <= cmd_b;
            opnd_op <= cmd_op;
            opnd_wr <= cmd_wr_acc;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_s     <= alu_s;
          res_c     <= alu_c;
          res_valid <= 1'b1;
          if (opnd_wr) begin
            acc <= alu_s;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            op_cnt    <= op_cnt + 1'b1;
            res_valid <= 1'b0;
            if (take_cmd) begin
              opnd_a  <= next_a;
              opnd_b  <= cmd_b;
              opnd_op <= cmd_op;
              opnd_wr <= cmd_wr_acc;
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_ctrl.sv
// tb_alu4_ctrl: directed-vector bench for alu4_ctrl. A second instance with
// a 2-bit counter and a non-zero accumulator init shares the stimulus.
module tb_alu4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       cmd_wr_acc;
  logic       res_ready;

  logic       cmd_ready,  cmd_ready2;
  logic [3:0] alu_a,      alu_a2;
  logic [3:0] alu_b,      alu_b2;
  logic [1:0] alu_op,     alu_op2;
  logic [3:0] alu_s,      alu_s2;
  logic       alu_c,      alu_c2;
  logic       res_valid,  res_valid2;
  logic [3:0] res_s,      res_s2;
  logic       res_c,      res_c2;
  logic [3:0] acc,        acc2;
  logic [7:0] op_cnt;
  logic [1:0] op_cnt2;

  int total = 0;
  int bad   = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU feeding each controller: {carry, sum}
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  assign {alu_c,  alu_s}  = alu_f(alu_a,  alu_b,  alu_op);
  assign {alu_c2, alu_s2} = alu_f(alu_a2, alu_b2, alu_op2);

  alu4_ctrl #(.CNT_W(8), .ACC_INIT(4'h0)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_c(res_c),
    .acc(acc), .op_cnt(op_cnt)
  );

  alu4_ctrl #(.CNT_W(2), .ACC_INIT(4'hA)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_s(alu_s2), .alu_c(alu_c2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_s(res_s2), .res_c(res_c2),
    .acc(acc2), .op_cnt(op_cnt2)
  );

  // Advance one clock and settle 1 ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one command on the cmd_* bus
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic use_acc,
                               input logic wr_acc);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    cmd_wr_acc  = wr_acc;
  endtask

  // Issue from IDLE with res_ready=1, check result timing and value, return to IDLE
  task automatic runOp(input string tag, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic use_acc, input logic wr_acc,
                       input logic [3:0] exp_s, input logic exp_c);
    checkOutput({tag, ".ready"}, cmd_ready, 1);
    applyStimulus(op, a, b, use_acc, wr_acc);
    tick();
    cmd_valid = 1'b0;
    checkOutput({tag, ".exec_valid"}, res_valid, 0);
    tick();
    checkOutput({tag, ".valid"}, res_valid, 1);
    checkOutput({tag, ".s"}, res_s, exp_s);
    checkOutput({tag, ".c"}, res_c, exp_c);
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'h0; cmd_b = 4'h0;
    cmd_use_acc = 1'b0; cmd_wr_acc = 1'b0; res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    checkOutput("rst.ready", cmd_ready, 1);
    checkOutput("rst.valid", res_valid, 0);
    checkOutput("rst.s", res_s, 0);
    checkOutput("rst.acc", acc, 0);
    checkOutput("rst.acc2", acc2, 4'hA);
    checkOutput("rst.cnt", op_cnt, 0);
    checkOutput("rst.alu_a", alu_a, 0);

    // basic arithmetic
    runOp("add53", 2'd0, 4'd5, 4'd3, 1'b0, 1'b1, 4'd8, 1'b0);
    checkOutput("add53.acc", acc, 8);
    checkOutput("add53.cnt", op_cnt, 1);
    runOp("sub35", 2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 4'd14, 1'b0);
    runOp("sub53", 2'd1, 4'd5, 4'd3, 1'b0, 1'b0, 4'd2, 1'b1);
    checkOutput("sub.acc", acc, 8);

    // accumulator chaining
    runOp("chain_add", 2'd0, 4'd0, 4'd9, 1'b1, 1'b1, 4'd1, 1'b1);
    checkOutput("chain_add.acc", acc, 1);
    runOp("chain_or", 2'd3, 4'd0, 4'd6, 1'b1, 1'b0, 4'd7, 1'b0);
    checkOutput("chain.cnt", op_cnt, 5);

    // backpressure with a waiting command
    res_ready = 1'b0;
    applyStimulus(2'd2, 4'd12, 4'd10, 1'b0, 1'b0);
    tick();
    applyStimulus(2'd0, 4'd1, 4'd1, 1'b0, 1'b0);
    checkOutput("bp.exec_ready", cmd_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d.valid", i), res_valid, 1);
      checkOutput($sformatf("bp%0d.s", i), res_s, 8);
      checkOutput($sformatf("bp%0d.ready", i), cmd_ready, 0);
      checkOutput($sformatf("bp%0d.cnt", i), op_cnt, 5);
      tick();
    end
    res_ready = 1'b1;
    #1;
    checkOutput("bp.release_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("bp.cnt", op_cnt, 6);
    checkOutput("bp.next_valid", res_valid, 0);
    checkOutput("bp.next_alu_a", alu_a, 1);
    tick();
    checkOutput("bp.next_s", res_s, 2);
    checkOutput("bp.next_valid2", res_valid, 1);
    tick();

    // forwarding: use_acc command accepted in HOLD sees freshly written acc
    applyStimulus(2'd0, 4'd2, 4'd3, 1'b0, 1'b1);
    tick();
    applyStimulus(2'd0, 4'd0, 4'd4, 1'b1, 1'b1);
    tick();
    checkOutput("fwd.s1", res_s, 5);
    checkOutput("fwd.acc1", acc, 5);
    tick();
    cmd_valid = 1'b0;
    checkOutput("fwd.alu_a", alu_a, 5);
    checkOutput("fwd.cnt1", op_cnt, 8);
    tick();
    checkOutput("fwd.s2", res_s, 9);
    checkOutput("fwd.acc2", acc, 9);
    tick();
    checkOutput("fwd.cnt", op_cnt, 9);
    checkOutput("fwd.cnt2", op_cnt2, 1);

    // reset during EXEC
    applyStimulus(2'd0, 4'd7, 4'd7, 1'b0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid.valid", res_valid, 0);
    checkOutput("mid.acc", acc, 0);
    checkOutput("mid.acc2", acc2, 4'hA);
    checkOutput("mid.cnt", op_cnt, 0);
    checkOutput("mid.ready", cmd_ready, 1);
    tick();
    checkOutput("mid.valid_after", res_valid, 0);
    checkOutput("mid.acc_after", acc, 0);

    // 2-bit counter wrap: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      runOp($sformatf("wrap%0d", i), 2'd0, 4'(i), 4'd1, 1'b0, 1'b0, 4'(i + 1), 1'b0);
      checkOutput($sformatf("wrap%0d.cnt2", i), op_cnt2, (i + 1) % 4);
      checkOutput($sformatf("wrap%0d.cnt", i), op_cnt, i + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu4_ctrl.md
Name: alu4_ctrl

Overview:
Command-side controller for the 4-bit ALU. It accepts operation commands over a valid/ready handshake and registers the operands. It drives the ALU's A/B/op inputs, captures the S/C result one cycle later, and returns that result over a second valid/ready handshake. It holds a 4-bit accumulator so operations can be chained, and it counts completed operations.

Parameters:
CNT_W, 8, width of completed-operation counter op_cnt.
ACC_INIT, 4'h0, accumulator value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command this cycle.
cmd_op  in  2  operation: 0=ADD, 1=SUB, 2=AND, 3=OR.
cmd_a  in  4  operand A, used when cmd_use_acc=0.
cmd_b  in  4  operand B.
cmd_use_acc  in  1  1: operand A is the accumulator; 0: operand A is cmd_a.
cmd_wr_acc  in  1  1: write the result S into the accumulator.
alu_a  out  4  to ALU input A.
alu_b  out  4  to ALU input B.
alu_op  out  2  to ALU op.
alu_s  in  4  from ALU result.
alu_c  in  1  from ALU carry flag.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_s  out  4  captured result.
res_c  out  1  captured carry; for SUB this is the no-borrow flag.
acc  out  4  current accumulator.
op_cnt  out  CNT_W  number of results accepted by the consumer.

Behaviour:
- One clock domain; all state changes on the rising edge of clk; rst is synchronous, active-high.
- Reset values: state=IDLE; cmd_ready=1; res_valid=0; res_s=0; res_c=0; alu_a=0; alu_b=0; alu_op=0; acc=ACC_INIT; op_cnt=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op, B, the wr_acc flag, and A (acc if cmd_use_acc, else cmd_a) into operand registers; go to EXEC.
  - EXEC: alu_a/alu_b/alu_op come straight from the operand registers; the ALU is combinational. At the end of the cycle: res_s<=alu_s, res_c<=alu_c; if wr_acc then acc<=alu_s. Go to HOLD. cmd_ready=0.
  - HOLD: res_valid=1, and res_s/res_c stay stable until the transfer. On res_ready: op_cnt increments.
    - If cmd_valid is also high this cycle: cmd_ready=1, the new command is latched, go to EXEC.
    - Otherwise go to IDLE.
    - Without res_ready: stay in HOLD, cmd_ready=0.
- cmd_ready = (state==IDLE) | (state==HOLD & res_ready). It may combinationally depend on res_ready; it never depends on cmd_valid.
- Latency: command accepted at edge N → ALU driven during cycle N+1 → res_valid high in cycle N+2. Sustained throughput is one operation per 2 cycles when res_ready is held high.
- Accumulator forwarding: a command with cmd_use_acc=1 accepted in HOLD sees acc as already updated by the previous EXEC.
- Operand registers hold their values outside EXEC, so alu_* do not toggle while idle.
- Arithmetic is defined by the ALU, all 4-bit modulo 16:
  - ADD: S=A+B, C=carry out.
  - SUB: S=A+~B+1, C=1 when A>=B.
  - AND/OR: C=0.
- op_cnt wraps from 2^CNT_W-1 to 0.
- rst asserted in any state aborts the operation: no result is produced, a pending result is dropped, acc returns to ACC_INIT, and the next cycle is IDLE.
- cmd_* fields are ignored when cmd_ready=0 or cmd_valid=0. res_ready is ignored when res_valid=0.

Test Plan:
- Reset, then ADD a=5 b=3 use_acc=0 wr_acc=1, res_ready=1 → res_valid in cycle 2 after accept; res_s=8, res_c=0, acc=8, op_cnt=1.
- SUB a=3 b=5 → res_s=14, res_c=0. Then SUB a=5 b=3 → res_s=2, res_c=1.
- Chain: acc=8, then ADD use_acc=1 b=9 wr_acc=1 → res_s=1, res_c=1, acc=1. Then OR use_acc=1 b=6 → res_s=7, res_c=0.
- Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 → res_valid stays 1, res_s stable, cmd_ready=0, op_cnt unchanged. Release res_ready → back-to-back accept with next res_valid 2 cycles later. AND a=12 b=10 → res_s=8.
- Reset mid-operation: assert rst in the EXEC cycle of ADD 7+7 wr_acc=1 → no res_valid, acc=ACC_INIT, op_cnt=0, cmd_ready=1 next cycle.
- Counter wrap: CNT_W=2, issue 5 operations → op_cnt sequence 1,2,3,0,1.
